// File: rtl/digit_serial_addsub_if.sv
// Handshake/operand/result bundle for digit_serial_addsub.
// REF_CHECK_EN adds the reference-adder outputs sumk, coutk and err.
interface digit_serial_addsub_if #(
    parameter int N = 64
);
    logic         start;
    logic         mode;
    logic [N-1:0] inp1;
    logic [N-1:0] inp2;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
`ifdef REF_CHECK_EN
    logic [N-1:0] sumk;
    logic         coutk;
    logic         err;

    modport master (output start, mode, inp1, inp2,
                    input  busy, done, sum, cout, ovf, sumk, coutk, err);
    modport slave  (input  start, mode, inp1, inp2,
                    output busy, done, sum, cout, ovf, sumk, coutk, err);
`else
    modport master (output start, mode, inp1, inp2,
                    input  busy, done, sum, cout, ovf);
    modport slave  (input  start, mode, inp1, inp2,
                    output busy, done, sum, cout, ovf);
`endif
endinterface

// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement add/sub, D bits per clock, N/D cycles per operation.
// Optional REF_CHECK_EN adds a single-cycle reference adder and a sticky mismatch flag.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// RUN   | one digit added per clock, N/D clocks total
// DONE  | done pulse cycle, busy still high
module digit_serial_addsub #(
    parameter int N = 64,
    parameter int D = 4
) (
    input logic                  clk,
    input logic                  rst,
    digit_serial_addsub_if.slave bus
);
    if ((D < 1) || (D > N) || ((N % D) != 0)) begin : g_bad_param
        $fatal(1, "digit_serial_addsub: D must divide N and lie in 1..N");
    end

    localparam int NDIG = N / D;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [N-1:0]  a_q, b_q, a_nxt, b_nxt, full;
    logic          carry_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  sum_q;
    logic          cout_q, ovf_q, busy_q, done_q;
    logic [D:0]    dsum;
    logic [D-1:0]  s_d;
    logic          c_d;

    assign dsum = {1'b0, a_q[D-1:0]} + {1'b0, b_q[D-1:0]} + {{D{1'b0}}, carry_q};
    assign s_d  = dsum[D-1:0];
    assign c_d  = dsum[D];

    // Earlier digits live in work_q; full is the result as it stands after this digit.
    if (D == N) begin : g_full
        assign a_nxt = '0;
        assign b_nxt = '0;
        assign full  = s_d;
    end else begin : g_part
        logic [N-D-1:0] work_q;
        assign a_nxt = {{D{1'b0}}, a_q[N-1:D]};
        assign b_nxt = {{D{1'b0}}, b_q[N-1:D]};
        assign full  = {s_d, work_q};
        always_ff @(posedge clk) begin
            if (rst)
                work_q <= '0;
            else if (state == RUN)
                work_q <= full[N-1:D];
        end
    end

    // On the last digit a_q/b_q[D-1] are the operand sign bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.inp1;
                        b_q     <= bus.mode ? ~bus.inp2 : bus.inp2;
                        carry_q <= bus.mode;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_nxt;
                    b_q     <= b_nxt;
                    carry_q <= c_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        sum_q  <= full;
                        cout_q <= c_d;
                        ovf_q  <= (a_q[D-1] == b_q[D-1]) && (s_d[D-1] != a_q[D-1]);
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

`ifdef REF_CHECK_EN
    logic [N-1:0] sumk_q;
    logic         coutk_q, err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sumk_q  <= '0;
            coutk_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && bus.start)
                {coutk_q, sumk_q} <= {1'b0, bus.inp1}
                                   + {1'b0, (bus.mode ? ~bus.inp2 : bus.inp2)}
                                   + {{N{1'b0}}, bus.mode};
            if (state == DONE && ({cout_q, sum_q} != {coutk_q, sumk_q}))
                err_q <= 1'b1;
        end
    end

    assign bus.sumk  = sumk_q;
    assign bus.coutk = coutk_q;
    assign bus.err   = err_q;
`endif
endmodule
